// File: rtl/scpu_pkg.sv
// Shared CPU-side definitions for the external output port and its UART consumer.
package scpu_pkg;

    localparam int unsigned BYTE_W = 8;

    // WB decode raises out_valid when an instruction with this opcode retires
    localparam logic [3:0] OP_OUT = 4'hE;

    localparam logic UART_IDLE = 1'b1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } tx_state_t;

endpackage

// File: rtl/byte_fifo.sv
// Small byte FIFO with occupancy count; full/empty are registered from the next count.
module byte_fifo
    import scpu_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic [BYTE_W-1:0]        din,
    output logic [BYTE_W-1:0]        dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [BYTE_W-1:0] mem [DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic              wr_en;
    logic              rd_en;
    logic [CW-1:0]     count_nxt;

    // A pop in the same cycle frees the slot a push into a full FIFO needs
    assign rd_en     = pop & ~empty;
    assign wr_en     = push & (~full | rd_en);
    assign count_nxt = count + CW'(wr_en) - CW'(rd_en);
    assign dout      = mem[rd_ptr];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            full   <= 1'b0;
            empty  <= 1'b1;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + AW'(1);
            if (rd_en) rd_ptr <= rd_ptr + AW'(1);
            count <= count_nxt;
            full  <= (count_nxt == CW'(DEPTH));
            empty <= (count_nxt == '0);
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/ext_out_uart_tx.sv
// Buffers bytes from the CPU OUT port and serialises them as 8N1 UART frames on tx.
module ext_out_uart_tx
    import scpu_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 16,
    parameter int unsigned FIFO_DEPTH   = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [BYTE_W-1:0] out_data,
    input  logic              out_valid,
    input  logic              clr_ovf,
    output logic              tx,
    output logic              busy,
    output logic              fifo_full,
    output logic              overflow
);

    localparam int unsigned BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int unsigned CNT_W  = $clog2(FIFO_DEPTH) + 1;
    localparam int unsigned BIT_W  = 3;
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(BYTE_W - 1);

    tx_state_t          state;
    tx_state_t          state_nxt;
    logic [BAUD_W-1:0]  baud;
    logic               baud_done;
    logic [BIT_W-1:0]   bit_idx;
    logic [BYTE_W-1:0]  shift;
    logic               tx_nxt;
    logic               pop;
    logic               push;
    logic               ovf_set;
    logic [BYTE_W-1:0]  fifo_dout;
    logic               fifo_empty;
    logic [CNT_W-1:0]   fifo_count;
    logic [CNT_W-1:0]   cnt_nxt;

    assign baud_done = (baud == BAUD_LAST);
    assign push      = out_valid & (~fifo_full | pop);
    assign ovf_set   = out_valid & fifo_full & ~pop;
    assign cnt_nxt   = fifo_count + CNT_W'(push) - CNT_W'(pop);

    byte_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .din   (out_data),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:  if (!fifo_empty) state_nxt = START;
            START: if (baud_done) state_nxt = DATA;
            DATA:  if (baud_done && bit_idx == BIT_LAST) state_nxt = STOP;
            STOP:  if (baud_done) state_nxt = fifo_empty ? IDLE : START;
            default: state_nxt = IDLE;
        endcase
    end

    // Pops happen on the edge that enters START, so a loaded byte is always framed
    always_comb begin
        pop    = 1'b0;
        tx_nxt = UART_IDLE;
        unique case (state)
            IDLE:  pop = ~fifo_empty;
            START: tx_nxt = 1'b0;
            DATA:  tx_nxt = shift[0];
            STOP: begin
                tx_nxt = 1'b1;
                pop    = baud_done & ~fifo_empty;
            end
            default: tx_nxt = UART_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            baud     <= '0;
            bit_idx  <= '0;
            shift    <= '0;
            tx       <= UART_IDLE;
            busy     <= 1'b0;
            overflow <= 1'b0;
        end else begin
            tx   <= tx_nxt;
            busy <= (state_nxt != IDLE) | (cnt_nxt != '0);

            if (state == IDLE || baud_done) baud <= '0;
            else                            baud <= baud + BAUD_W'(1);

            if (pop)                          shift <= fifo_dout;
            else if (state == DATA && baud_done) shift <= shift >> 1;

            if (state == START)                  bit_idx <= '0;
            else if (state == DATA && baud_done) bit_idx <= bit_idx + BIT_W'(1);

            // A new drop outranks a simultaneous software clear
            if (ovf_set)      overflow <= 1'b1;
            else if (clr_ovf) overflow <= 1'b0;
        end
    end

endmodule

// File: tb/tb_ext_out_uart_tx.sv
// Self-checking bench for ext_out_uart_tx: hand table, directed corner sequences, random traffic vs frame model.
module tb_ext_out_uart_tx;

    localparam int CPB   = 4;
    localparam int DEPTH = 4;
    localparam int FRAME = 10 * CPB;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [7:0] out_data = 8'h00;
    logic       out_valid = 1'b0;
    logic       clr_ovf = 1'b0;
    logic       tx;
    logic       busy;
    logic       fifo_full;
    logic       overflow;

    int vectors = 0;
    int miscompares = 0;

    // Reference model: queue of waiting bytes plus the frame currently on the line
    logic [7:0] m_q[$];
    logic       m_active;
    int         m_age;
    logic [7:0] m_cur;
    logic       m_ovf;
    logic       e_tx, e_busy, e_full, e_ovf;

    typedef struct {
        logic       v;
        logic [7:0] d;
        logic       clr;
        logic [3:0] exp;
    } vec_t;

    vec_t tbl[10];

    ext_out_uart_tx #(
        .CLKS_PER_BIT (CPB),
        .FIFO_DEPTH   (DEPTH)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .out_data  (out_data),
        .out_valid (out_valid),
        .clr_ovf   (clr_ovf),
        .tx        (tx),
        .busy      (busy),
        .fifo_full (fifo_full),
        .overflow  (overflow)
    );

    always #5 clk = ~clk;

    function automatic logic [3:0] outs();
        return {tx, busy, fifo_full, overflow};
    endfunction

    task automatic check(input string name, input logic [3:0] got, input logic [3:0] want);
        vectors++;
        if (got !== want) begin
            miscompares++;
            $display("FAIL %s at %0t: tx/busy/full/ovf got %b required %b", name, $time, got, want);
        end
    endtask

    task automatic model_reset();
        m_q.delete();
        m_active = 1'b0;
        m_age    = 0;
        m_cur    = 8'h00;
        m_ovf    = 1'b0;
    endtask

    // One clock edge of the model: line slot = frame age / CPB, tx shows the slot one cycle late
    task automatic model_step(input logic v, input logic [7:0] d, input logic clr);
        logic [9:0] frame;
        logic       pop_now;
        logic       accept;
        frame   = {1'b1, m_cur, 1'b0};
        e_tx    = m_active ? frame[4'(m_age / CPB)] : 1'b1;
        pop_now = 1'b0;
        if (m_active && m_age == FRAME - 1) m_active = 1'b0;
        if (!m_active && m_q.size() != 0) pop_now = 1'b1;
        accept = v && (m_q.size() < DEPTH || pop_now);
        if (pop_now) begin
            m_cur    = m_q.pop_front();
            m_active = 1'b1;
            m_age    = 0;
        end else if (m_active) begin
            m_age++;
        end
        if (accept) m_q.push_back(d);
        if (v && !accept) m_ovf = 1'b1;
        else if (clr)     m_ovf = 1'b0;
        e_busy = m_active || (m_q.size() != 0);
        e_full = (m_q.size() == DEPTH);
        e_ovf  = m_ovf;
    endtask

    task automatic cycle(input logic v, input logic [7:0] d, input logic clr);
        out_valid = v;
        out_data  = d;
        clr_ovf   = clr;
        @(posedge clk);
        model_step(v, d, clr);
        #1;
        check("model", outs(), {e_tx, e_busy, e_full, e_ovf});
        out_valid = 1'b0;
        clr_ovf   = 1'b0;
    endtask

    initial begin
        logic found;
        int   pct;

        tbl[0] = '{1'b1, 8'h11, 1'b0, 4'b1100};
        tbl[1] = '{1'b1, 8'h22, 1'b0, 4'b1100};
        tbl[2] = '{1'b1, 8'h33, 1'b0, 4'b0100};
        tbl[3] = '{1'b1, 8'h44, 1'b0, 4'b0100};
        tbl[4] = '{1'b1, 8'h55, 1'b0, 4'b0110};
        tbl[5] = '{1'b1, 8'h66, 1'b0, 4'b0111};
        tbl[6] = '{1'b0, 8'h00, 1'b1, 4'b1110};
        tbl[7] = '{1'b1, 8'h77, 1'b1, 4'b1111};
        tbl[8] = '{1'b0, 8'h00, 1'b1, 4'b1110};
        tbl[9] = '{1'b0, 8'h00, 1'b0, 4'b1110};

        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check("reset_initial", outs(), 4'b1000);
        rst = 1'b1;

        // Fill, overflow, clear, and set-beats-clear while the first frame runs
        for (int i = 0; i < 10; i++) begin
            cycle(tbl[i].v, tbl[i].d, tbl[i].clr);
            check($sformatf("table[%0d]", i), outs(), tbl[i].exp);
        end

        // Async reset while the line is low, FIFO full and overflow set
        cycle(1'b1, 8'h88, 1'b0);
        check("pre_reset", outs(), 4'b0111);
        #1 rst = 1'b0;
        #1 check("reset_async", outs(), 4'b1000);
        model_reset();
        @(posedge clk);
        #1 rst = 1'b1;
        repeat (60) cycle(1'b0, 8'h00, 1'b0);

        // Single byte latency: tx falls two edges after the push
        cycle(1'b1, 8'hA5, 1'b0);
        check("a5_push", outs(), 4'b1100);
        cycle(1'b0, 8'h00, 1'b0);
        check("a5_pop", outs(), 4'b1100);
        cycle(1'b0, 8'h00, 1'b0);
        check("a5_start", outs(), 4'b0100);
        repeat (FRAME + 10) cycle(1'b0, 8'h00, 1'b0);
        check("a5_idle", outs(), 4'b1000);

        // Burst of five consecutive pushes
        for (int i = 1; i <= 5; i++) cycle(1'b1, 8'(i), 1'b0);
        repeat (5 * FRAME + 10) cycle(1'b0, 8'h00, 1'b0);
        check("burst_idle", outs(), 4'b1000);

        // Push into a full FIFO on the STOP->START edge
        for (int i = 0; i < 5; i++) cycle(1'b1, 8'(8'h30 + i), 1'b0);
        found = 1'b0;
        for (int k = 0; k < 2 * FRAME; k++) begin
            if (!found && m_active && m_age == FRAME - 1 && m_q.size() == DEPTH) begin
                cycle(1'b1, 8'h7E, 1'b0);
                check("push_pop_full", {2'b00, fifo_full, overflow}, 4'b0010);
                found = 1'b1;
            end else begin
                cycle(1'b0, 8'h00, 1'b0);
            end
        end
        check("push_pop_window", {3'b000, found}, 4'b0001);
        repeat (6 * FRAME) cycle(1'b0, 8'h00, 1'b0);

        // Random traffic alternating sparse and dense phases
        for (int k = 0; k < 1500; k++) begin
            pct = ((k / 150) % 2 == 1) ? 50 : 4;
            cycle(($urandom_range(0, 99) < pct), 8'($urandom), ($urandom_range(0, 40) == 0));
        end
        repeat (6 * FRAME) cycle(1'b0, 8'h00, 1'b0);
        check("final_idle", {tx, busy, fifo_full, 1'b0}, 4'b1000);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
